// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared types and byte-lane merge helper for the dual-port RAM
package memory_pkg;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAXW = 1024;
  localparam int MAXB = MAXW / 8;

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_e;
  typedef enum logic {RDW_OLD = 1'b0, RDW_NEW = 1'b1} rdw_mode_e;

  // Per-byte merge of two port writes onto an old word.
  // A lane enabled by one port takes that port's byte; a lane enabled by
  // both takes port B's byte when prio is set, otherwise port A's.
  function automatic logic [MAXW-1:0] byte_merge(
    input logic [MAXW-1:0] old,
    input logic [MAXW-1:0] da,
    input logic [MAXB-1:0] bea,
    input logic [MAXW-1:0] db,
    input logic [MAXB-1:0] beb,
    input logic            prio
  );
    logic [MAXW-1:0] r;
    r = old;
    for (int i = 0; i < MAXB; i++) begin
      if (bea[i] && beb[i]) begin
        r[i*8 +: 8] = prio ? db[i*8 +: 8] : da[i*8 +: 8];
      end else if (bea[i]) begin
        r[i*8 +: 8] = da[i*8 +: 8];
      end else if (beb[i]) begin
        r[i*8 +: 8] = db[i*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/memory_init_seq.sv
// rtl/memory_init_seq.sv - clear sequencer: walks every word writing the fill value
module memory_init_seq
  import memory_pkg::*;
#(
  parameter int N  = 32,
  parameter int D  = 16,
  parameter int A  = $clog2(D),
  parameter bit RV = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         init,
  output logic         busy,
  output logic         accept,
  output logic         clr_we,
  output logic [A-1:0] clr_addr,
  output logic [N-1:0] clr_data
);

  localparam logic [A-1:0] LAST = A'(D - 1);

  state_e       state;
  state_e       state_nxt;
  logic [A-1:0] cnt;
  logic [A-1:0] cnt_nxt;

  // State and clear-address registers; reset always restarts the clear from 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: clear runs to the last word; init only takes effect from IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + A'(1);
        end
      end
      IDLE: begin
        if (init) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: port traffic is accepted only in IDLE and not in an init cycle
  always_comb begin
    busy     = (state == CLEAR);
    accept   = (state == IDLE) && !init;
    clr_we   = (state == CLEAR);
    clr_addr = cnt;
    clr_data = {N{RV}};
  end

endmodule

// File: rtl/memory_true_dual_port_be.sv
// rtl/memory_true_dual_port_be.sv - true dual-port RAM with byte enables and collision merge
module memory_true_dual_port_be
  import memory_pkg::*;
#(
  parameter int N    = 32,
  parameter int D    = 16,
  parameter int A    = $clog2(D),
  parameter int NB   = N / 8,
  parameter bit RV   = 1'b0,
  parameter int RDW  = 0,
  parameter bit PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          init,
  output logic          busy,
  input  logic          wrena,
  input  logic          rdena,
  input  logic [NB-1:0] bena,
  input  logic [A-1:0]  addra,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata,
  output logic          rvlda,
  input  logic          wrenb,
  input  logic          rdenb,
  input  logic [NB-1:0] benb,
  input  logic [A-1:0]  addrb,
  input  logic [N-1:0]  wdatb,
  output logic [N-1:0]  rdatb,
  output logic          rvldb,
  output logic          coll
);

  localparam logic [N-1:0] FILL     = {N{RV}};
  localparam logic [A:0]   DLIM     = (A + 1)'(D);
  localparam rdw_mode_e    RDW_MODE = (RDW != 0) ? RDW_NEW : RDW_OLD;

  logic [N-1:0] mem [D];

  logic          accept;
  logic          clr_we;
  logic [A-1:0]  clr_addr;
  logic [N-1:0]  clr_data;

  logic          ina, inb, same;
  logic          wa_ok, wb_ok, rd_a, rd_b;
  logic [NB-1:0] bea_a, beb_a, bea_b, beb_b;
  logic [N-1:0]  old_a, old_b, mrg_a, mrg_b;
  logic [N-1:0]  rd_word_a, rd_word_b;

  logic          wp_a_en;
  logic [A-1:0]  wp_a_addr;
  logic [N-1:0]  wp_a_data;

  memory_init_seq #(
    .N  (N),
    .D  (D),
    .A  (A),
    .RV (RV)
  ) u_init_seq (
    .clk      (clk),
    .rstn     (rstn),
    .init     (init),
    .busy     (busy),
    .accept   (accept),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_data (clr_data)
  );

  // Qualify both ports, then build each port's post-write word. Each merge
  // sees the other port's lanes only when both target the same address, so
  // in a collision both ports compute the identical merged word.
  always_comb begin
    ina   = ({1'b0, addra} < DLIM);
    inb   = ({1'b0, addrb} < DLIM);
    same  = (addra == addrb);
    old_a = ina ? mem[addra] : FILL;
    old_b = inb ? mem[addrb] : FILL;
    wa_ok = accept && wrena && ina && (|bena);
    wb_ok = accept && wrenb && inb && (|benb);
    rd_a  = accept && rdena;
    rd_b  = accept && rdenb;

    bea_a = wa_ok ? bena : '0;
    beb_a = (wb_ok && same) ? benb : '0;
    bea_b = (wa_ok && same) ? bena : '0;
    beb_b = wb_ok ? benb : '0;

    mrg_a = N'(byte_merge(MAXW'(old_a), MAXW'(wdata), MAXB'(bea_a),
                          MAXW'(wdatb), MAXB'(beb_a), PRIO));
    mrg_b = N'(byte_merge(MAXW'(old_b), MAXW'(wdata), MAXB'(bea_b),
                          MAXW'(wdatb), MAXB'(beb_b), PRIO));

    if (!ina) begin
      rd_word_a = FILL;
    end else if (RDW_MODE == RDW_NEW) begin
      rd_word_a = mrg_a;
    end else begin
      rd_word_a = old_a;
    end

    if (!inb) begin
      rd_word_b = FILL;
    end else if (RDW_MODE == RDW_NEW) begin
      rd_word_b = mrg_b;
    end else begin
      rd_word_b = old_b;
    end
  end

  // Write port A is shared between the clear sequencer and port A traffic;
  // the two never overlap because traffic is refused while clearing.
  always_comb begin
    wp_a_en   = clr_we || wa_ok;
    wp_a_addr = clr_we ? clr_addr : addra;
    wp_a_data = clr_we ? clr_data : mrg_a;
  end

  // Array update; a same-address collision writes the same word twice
  always_ff @(posedge clk) begin
    if (wp_a_en) begin
      mem[wp_a_addr] <= wp_a_data;
    end
    if (wb_ok) begin
      mem[addrb] <= mrg_b;
    end
  end

  // Registered read data, valids and collision flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= FILL;
      rdatb <= FILL;
      rvlda <= 1'b0;
      rvldb <= 1'b0;
      coll  <= 1'b0;
    end else begin
      rvlda <= rd_a;
      rvldb <= rd_b;
      coll  <= wa_ok && wb_ok && same;
      if (rd_a) begin
        rdata <= rd_word_a;
      end
      if (rd_b) begin
        rdatb <= rd_word_b;
      end
    end
  end

endmodule

// File: tb/tb_memory_true_dual_port_be.sv
// tb/tb_memory_true_dual_port_be.sv - directed self-checking bench for the dual-port RAM
module tb_memory_true_dual_port_be;

  logic        clk = 1'b0;
  logic        rstn;
  logic        init;
  logic        wrena, rdena, wrenb, rdenb;
  logic [3:0]  bena, benb;
  logic [3:0]  addra, addrb;
  logic [31:0] wdata, wdatb;

  logic        busy0, rvlda0, rvldb0, coll0;
  logic [31:0] rdata0, rdatb0;
  logic        busy1, rvlda1, rvldb1, coll1;
  logic [31:0] rdata1, rdatb1;

  int tests = 0;
  int fails = 0;
  int n, n0, n1;

  always #5 clk = ~clk;

  // dut0: D=16, read-first, port A priority
  memory_true_dual_port_be #(.N(32), .D(16), .RV(1'b0), .RDW(0), .PRIO(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .init(init), .busy(busy0),
    .wrena(wrena), .rdena(rdena), .bena(bena), .addra(addra), .wdata(wdata),
    .rdata(rdata0), .rvlda(rvlda0),
    .wrenb(wrenb), .rdenb(rdenb), .benb(benb), .addrb(addrb), .wdatb(wdatb),
    .rdatb(rdatb0), .rvldb(rvldb0), .coll(coll0)
  );

  // dut1: D=12, write-first, port B priority
  memory_true_dual_port_be #(.N(32), .D(12), .RV(1'b0), .RDW(1), .PRIO(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .init(init), .busy(busy1),
    .wrena(wrena), .rdena(rdena), .bena(bena), .addra(addra), .wdata(wdata),
    .rdata(rdata1), .rvlda(rvlda1),
    .wrenb(wrenb), .rdenb(rdenb), .benb(benb), .addrb(addrb), .wdatb(wdatb),
    .rdatb(rdatb1), .rvldb(rvldb1), .coll(coll1)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    init  = 1'b0;
    wrena = 1'b0; rdena = 1'b0; bena = 4'h0; addra = 4'h0; wdata = 32'h0;
    wrenb = 1'b0; rdenb = 1'b0; benb = 4'h0; addrb = 4'h0; wdatb = 32'h0;
  endtask

  // Counts edges until both instances leave the clear sequence
  task automatic wait_idle(input int init_at, input int wr_at);
    n = 0; n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy0 && n0 == 0) n0 = n;
      if (!busy1 && n1 == 0) n1 = n;
      init  = (n == init_at);
      wrena = (n == wr_at);
    end
    init  = 1'b0;
    wrena = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    quiet();
    rstn = 1'b1;
    #3 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk1 ("rst_busy0",  busy0,  1'b1);
    chk1 ("rst_busy1",  busy1,  1'b1);
    chk1 ("rst_rvlda0", rvlda0, 1'b0);
    chk1 ("rst_rvldb0", rvldb0, 1'b0);
    chk1 ("rst_coll0",  coll0,  1'b0);
    chk32("rst_rdata0", rdata0, 32'h0);
    chk32("rst_rdatb1", rdatb1, 32'h0);

    // Clear length after release; init pulse during clear is ignored
    rstn = 1'b1;
    wait_idle(5, -1);
    chk32("clear_len0", n0, 16);
    chk32("clear_len1", n1, 12);

    // 1: read of a cleared word
    rdena = 1'b1; addra = 4'd5;
    tick();
    quiet();
    chk32("t1_rdata0", rdata0, 32'h0);
    chk1 ("t1_rvlda0", rvlda0, 1'b1);
    chk32("t1_rdata1", rdata1, 32'h0);
    tick();
    chk1 ("t1_rvld_drop", rvlda0, 1'b0);

    // 2: byte-enable partial overwrite
    wrena = 1'b1; addra = 4'd3; wdata = 32'hDEADBEEF; bena = 4'b1111;
    tick();
    wdata = 32'h11223344; bena = 4'b0101;
    tick();
    quiet();
    rdenb = 1'b1; addrb = 4'd3;
    tick();
    quiet();
    chk32("t2_rdatb0", rdatb0, 32'hDE22BE44);
    chk1 ("t2_rvldb0", rvldb0, 1'b1);
    chk32("t2_rdatb1", rdatb1, 32'hDE22BE44);

    // 3: same-address collision, overlapping bytes
    wrena = 1'b1; addra = 4'd7; wdata = 32'hAAAAAAAA; bena = 4'b1111;
    wrenb = 1'b1; addrb = 4'd7; wdatb = 32'h55555555; benb = 4'b0011;
    tick();
    quiet();
    chk1 ("t3_coll0", coll0, 1'b1);
    chk1 ("t3_coll1", coll1, 1'b1);
    rdena = 1'b1; addra = 4'd7;
    tick();
    quiet();
    chk1 ("t3_coll0_once", coll0, 1'b0);
    chk32("t3_prio0", rdata0, 32'hAAAAAAAA);
    chk32("t3_prio1", rdata1, 32'hAAAA5555);

    // 3b: collision on disjoint bytes still flags and merges both
    wrena = 1'b1; addra = 4'd8; wdata = 32'hAABB0000; bena = 4'b1100;
    wrenb = 1'b1; addrb = 4'd8; wdatb = 32'h0000CCDD; benb = 4'b0011;
    tick();
    quiet();
    chk1 ("t3b_coll0", coll0, 1'b1);
    rdenb = 1'b1; addrb = 4'd8;
    tick();
    quiet();
    chk32("t3b_merge0", rdatb0, 32'hAABBCCDD);
    chk32("t3b_merge1", rdatb1, 32'hAABBCCDD);

    // 4: read-during-write, cross port then same port
    wrena = 1'b1; addra = 4'd2; wdata = 32'h1; bena = 4'b1111;
    tick();
    wdata = 32'h2;
    rdenb = 1'b1; addrb = 4'd2;
    tick();
    quiet();
    chk32("t4_cross_old", rdatb0, 32'h1);
    chk32("t4_cross_new", rdatb1, 32'h2);
    wrena = 1'b1; rdena = 1'b1; addra = 4'd2; wdata = 32'h3; bena = 4'b1111;
    tick();
    quiet();
    chk32("t4_same_old", rdata0, 32'h2);
    chk32("t4_same_new", rdata1, 32'h3);

    // 5: out-of-range write and read on the D=12 instance
    wrena = 1'b1; addra = 4'd13; wdata = 32'hFFFFFFFF; bena = 4'b1111;
    tick();
    quiet();
    rdena = 1'b1; addra = 4'd13;
    rdenb = 1'b1; addrb = 4'd1;
    tick();
    quiet();
    chk32("t5_oor_rdata1", rdata1, 32'h0);
    chk1 ("t5_oor_rvlda1", rvlda1, 1'b1);
    chk32("t5_addr1_rdatb1", rdatb1, 32'h0);
    chk1 ("t5_addr1_rvldb1", rvldb1, 1'b1);
    chk32("t5_inrange_rdata0", rdata0, 32'hFFFFFFFF);

    // 6: init with a same-cycle write/read, then reset mid-clear
    init = 1'b1;
    wrena = 1'b1; addra = 4'd4; wdata = 32'h44444444; bena = 4'b1111;
    rdenb = 1'b1; addrb = 4'd3;
    tick();
    quiet();
    chk1("t6_busy0", busy0, 1'b1);
    chk1("t6_init_rvldb0", rvldb0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        rdena = 1'b1; addra = 4'd0;
        wrena = 1'b1; bena = 4'b1111; wdata = 32'h1;
        wrenb = 1'b1; addrb = 4'd0; benb = 4'b1111; wdatb = 32'h2;
      end
      tick();
      quiet();
      if (k == 2) begin
        chk1("t6_busy_rvlda0", rvlda0, 1'b0);
        chk1("t6_busy_coll0",  coll0,  1'b0);
      end
    end
    rstn = 1'b0;
    #1;
    chk1("t6_rst_busy0", busy0, 1'b1);
    chk1("t6_rst_rvld0", rvlda0, 1'b0);
    tick();
    rstn = 1'b1;
    addra = 4'd2; bena = 4'b1111; wdata = 32'h12345678;
    wait_idle(-1, 6);
    quiet();
    chk32("t6_clear_len0", n0, 16);
    chk32("t6_clear_len1", n1, 12);
    for (int i = 0; i < 16; i++) begin
      rdena = 1'b1; addra = 4'(i);
      tick();
      quiet();
      chk32($sformatf("t6_clr0_a%0d", i), rdata0, 32'h0);
      chk32($sformatf("t6_clr1_a%0d", i), rdata1, 32'h0);
      chk1 ($sformatf("t6_rvld_a%0d", i), rvlda0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
